// File: rtl/residue_idct4x4_if.sv
// Coefficient-in / residue-out handshake bundle for the 4x4 residue IDCT stage.
interface residue_idct4x4_if #(
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned RES_WIDTH   = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [COEFF_WIDTH-1:0] coeff [16];
  logic        [5:0]             qp;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [RES_WIDTH-1:0]   residue [16];
  logic                          busy;

  modport master (
    output in_valid, coeff, qp, out_ready,
    input  in_ready, out_valid, residue, busy
  );

  modport slave (
    input  in_valid, coeff, qp, out_ready,
    output in_ready, out_valid, residue, busy
  );
endinterface

// File: rtl/residue_idct4x4.sv
// Dequantize a 4x4 luma coefficient block, apply the H.264 4x4 inverse integer
// transform (rows then columns, one vector per cycle), then round and clamp.
module residue_idct4x4 #(
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned RES_WIDTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  residue_idct4x4_if.slave  bus
);
  localparam int unsigned MW = 22;
  localparam int unsigned RW = 24;
  localparam logic [5:0]  QP_MAX = 6'd51;
  localparam logic signed [RW-1:0] RES_MAX = RW'((1 << (RES_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] RES_MIN = ~RES_MAX;

  typedef enum logic [3:0] {
    S_IDLE, S_DEQUANT, S_ROW0, S_ROW1, S_ROW2, S_ROW3,
    S_COL0, S_COL1, S_COL2, S_COL3, S_ROUND, S_OUT
  } state_t;

  state_t state, state_nx;

  logic signed [COEFF_WIDTH-1:0] coeff_q [16];
  logic        [5:0]             qp_q;
  logic signed [MW-1:0]          m [16];
  logic signed [RES_WIDTH-1:0]   res_q [16];
  logic                          in_ready_q, out_valid_q, busy_q;

  logic                          is_row;
  logic        [1:0]             lane;
  logic        [3:0]             idx [4];
  logic signed [MW-1:0]          bf_in [4];
  logic signed [MW-1:0]          bf_out [4];
  logic signed [MW-1:0]          e0, e1, e2, e3;

  // Scale one coefficient by its position-dependent factor and saturate to 16 bits.
  function automatic logic signed [MW-1:0] dequant(
    input logic signed [COEFF_WIDTH-1:0] c,
    input logic [5:0] qp,
    input logic r_odd,
    input logic c_odd
  );
    logic [4:0]         v0, v1, v2, v;
    logic [3:0]         sh;
    logic [2:0]         rem;
    logic signed [31:0] p;
    rem = 3'(qp % 6'd6);
    sh  = 4'(qp / 6'd6);
    unique case (rem)
      3'd0:    begin v0 = 5'd10; v1 = 5'd16; v2 = 5'd13; end
      3'd1:    begin v0 = 5'd11; v1 = 5'd18; v2 = 5'd14; end
      3'd2:    begin v0 = 5'd13; v1 = 5'd20; v2 = 5'd16; end
      3'd3:    begin v0 = 5'd14; v1 = 5'd23; v2 = 5'd18; end
      3'd4:    begin v0 = 5'd16; v1 = 5'd25; v2 = 5'd20; end
      default: begin v0 = 5'd18; v1 = 5'd29; v2 = 5'd23; end
    endcase
    if (!r_odd && !c_odd)    v = v0;
    else if (r_odd && c_odd) v = v1;
    else                     v = v2;
    p = (32'(c) * $signed({27'd0, v})) <<< sh;
    if (p > 32'sd32767)       return MW'(32'sd32767);
    else if (p < -32'sd32768) return MW'(-32'sd32768);
    else                      return MW'(p);
  endfunction

  // Round a transform output to the residue scale and clamp to the signed output range.
  function automatic logic signed [RES_WIDTH-1:0] round_clamp(input logic signed [MW-1:0] x);
    logic signed [RW-1:0] t;
    t = (RW'(x) + RW'(32)) >>> 6;
    if (t > RES_MAX)      return RES_WIDTH'(RES_MAX);
    else if (t < RES_MIN) return RES_WIDTH'(RES_MIN);
    else                  return RES_WIDTH'(t);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state sequencing through the fixed pipeline of phases.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (bus.in_valid && in_ready_q) state_nx = S_DEQUANT;
      S_DEQUANT: state_nx = S_ROW0;
      S_ROW0:    state_nx = S_ROW1;
      S_ROW1:    state_nx = S_ROW2;
      S_ROW2:    state_nx = S_ROW3;
      S_ROW3:    state_nx = S_COL0;
      S_COL0:    state_nx = S_COL1;
      S_COL1:    state_nx = S_COL2;
      S_COL2:    state_nx = S_COL3;
      S_COL3:    state_nx = S_ROUND;
      S_ROUND:   state_nx = S_OUT;
      S_OUT:     if (bus.out_ready) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Select the row or column being transformed and run the shared butterfly on it.
  always_comb begin
    is_row = (state inside {S_ROW0, S_ROW1, S_ROW2, S_ROW3});
    unique case (state)
      S_ROW1, S_COL1: lane = 2'd1;
      S_ROW2, S_COL2: lane = 2'd2;
      S_ROW3, S_COL3: lane = 2'd3;
      default:        lane = 2'd0;
    endcase
    for (int j = 0; j < 4; j++) begin
      idx[j]   = is_row ? {lane, 2'(j)} : {2'(j), lane};
      bf_in[j] = m[idx[j]];
    end
    e0 = bf_in[0] + bf_in[2];
    e1 = bf_in[0] - bf_in[2];
    e2 = (bf_in[1] >>> 1) - bf_in[3];
    e3 = bf_in[1] + (bf_in[3] >>> 1);
    bf_out[0] = e0 + e3;
    bf_out[1] = e1 + e2;
    bf_out[2] = e1 - e2;
    bf_out[3] = e0 - e3;
  end

  // Datapath registers and registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        coeff_q[i] <= '0;
        m[i]       <= '0;
        res_q[i]   <= '0;
      end
      qp_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= (state_nx == S_IDLE);
      out_valid_q <= (state_nx == S_OUT);
      busy_q      <= (state_nx != S_IDLE);
      unique case (state)
        S_IDLE: if (bus.in_valid && in_ready_q) begin
          for (int i = 0; i < 16; i++) coeff_q[i] <= bus.coeff[i];
          qp_q <= (bus.qp > QP_MAX) ? QP_MAX : bus.qp;
        end
        S_DEQUANT: for (int i = 0; i < 16; i++)
          m[i] <= dequant(coeff_q[i], qp_q, i[2], i[0]);
        S_ROW0, S_ROW1, S_ROW2, S_ROW3, S_COL0, S_COL1, S_COL2, S_COL3:
          for (int j = 0; j < 4; j++) m[idx[j]] <= bf_out[j];
        S_ROUND: for (int i = 0; i < 16; i++) res_q[i] <= round_clamp(m[i]);
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.residue   = res_q;
endmodule

// File: tb/tb_residue_idct4x4.sv
// Directed self-checking bench for residue_idct4x4.
module tb_residue_idct4x4;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  residue_idct4x4_if #(.COEFF_WIDTH(16), .RES_WIDTH(8)) bus ();

  residue_idct4x4 #(.COEFF_WIDTH(16), .RES_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Put a single nonzero coefficient on the input bus.
  task automatic set_in(input int idx, input int val, input int qpv);
    for (int i = 0; i < 16; i++) bus.coeff[i] = '0;
    bus.coeff[idx] = 16'(val);
    bus.qp = 6'(qpv);
  endtask

  // Raise in_valid until the block is accepted; returns 1ns after the accepting edge.
  task automatic accept(output bit ok);
    ok = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
  endtask

  // Count rising edges until out_valid is seen; -1 if it never rises.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = e; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_in(0, 0, 0);
    #12;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.residue[i] !== 8'sd0) begin n_bad++; $display("FAIL reset_residue[%0d] got %0d want 0", i, bus.residue[i]); end
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_zero();
    bit ok; int lat;
    set_in(0, 0, 28);
    accept(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL zero_accept got timeout want accept"); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy got %b want 1", bus.busy); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL zero_in_ready got %b want 0", bus.in_ready); end
    wait_out(lat);
    n_cmp++; if (lat != 10) begin n_bad++; $display("FAIL zero_latency got %0d want 10", lat); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.residue[i] !== 8'sd0) begin n_bad++; $display("FAIL zero_residue[%0d] got %0d want 0", i, bus.residue[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_dc();
    bit ok; int lat;
    set_in(0, 4, 24);
    accept(ok);
    wait_out(lat);
    n_cmp++; if (lat != 10) begin n_bad++; $display("FAIL dc_latency got %0d want 10", lat); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.residue[i] !== 8'sd10) begin n_bad++; $display("FAIL dc_residue[%0d] got %0d want 10", i, bus.residue[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_pattern();
    bit ok; int lat;
    int pat [4] = '{7, 3, -3, -6};
    // coeff[1]=2 at qp 24: horizontal AC, each row reads 7,3,-3,-6
    set_in(1, 2, 24);
    accept(ok);
    wait_out(lat);
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.residue[i] !== 8'(pat[i % 4])) begin n_bad++; $display("FAIL hpat_residue[%0d] got %0d want %0d", i, bus.residue[i], pat[i % 4]); end
    end
    @(posedge clk); #1;
    // coeff[4]=2 is the transpose: each column reads 7,3,-3,-6
    set_in(4, 2, 24);
    accept(ok);
    wait_out(lat);
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.residue[i] !== 8'(pat[i / 4])) begin n_bad++; $display("FAIL vpat_residue[%0d] got %0d want %0d", i, bus.residue[i], pat[i / 4]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    bit ok; int lat;
    set_in(0, 32767, 51);
    accept(ok);
    wait_out(lat);
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.residue[i] !== 8'sd127) begin n_bad++; $display("FAIL sat_pos_residue[%0d] got %0d want 127", i, bus.residue[i]); end
    end
    @(posedge clk); #1;
    set_in(0, -32768, 51);
    accept(ok);
    wait_out(lat);
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.residue[i] !== -8'sd128) begin n_bad++; $display("FAIL sat_neg_residue[%0d] got %0d want -128", i, bus.residue[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_qp_clamp();
    bit ok; int lat;
    int qps [2] = '{51, 63};
    // coeff[0]=1: qp 51 gives 3584 -> 56; an unclamped qp 63 would give 127
    for (int k = 0; k < 2; k++) begin
      set_in(0, 1, qps[k]);
      accept(ok);
      wait_out(lat);
      n_cmp++; if (bus.residue[0] !== 8'sd56) begin n_bad++; $display("FAIL qp%0d_residue0 got %0d want 56", qps[k], bus.residue[0]); end
      n_cmp++; if (bus.residue[15] !== 8'sd56) begin n_bad++; $display("FAIL qp%0d_residue15 got %0d want 56", qps[k], bus.residue[15]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold_out();
    bit ok; int lat;
    bus.out_ready = 1'b0;
    set_in(0, 4, 24);
    accept(ok);
    wait_out(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      set_in(0, -32768, 51);
      bus.in_valid = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_out_valid got %b want 1", bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready got %b want 0", bus.in_ready); end
      n_cmp++; if (bus.residue[5] !== 8'sd10) begin n_bad++; $display("FAIL hold_residue got %0d want 10", bus.residue[5]); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release_in_ready got %b want 1", bus.in_ready); end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL hold_no_latch_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.residue[0] !== 8'sd10) begin n_bad++; $display("FAIL hold_keep_residue got %0d want 10", bus.residue[0]); end
  endtask

  task automatic test_reset_mid();
    bit ok; int lat;
    set_in(0, 32767, 51);
    accept(ok);
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.residue[i] !== 8'sd0) begin n_bad++; $display("FAIL rstmid_residue[%0d] got %0d want 0", i, bus.residue[i]); end
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready got %b want 1", bus.in_ready); end
    set_in(0, 4, 24);
    accept(ok);
    wait_out(lat);
    n_cmp++; if (lat != 10) begin n_bad++; $display("FAIL rstmid_latency got %0d want 10", lat); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.residue[i] !== 8'sd10) begin n_bad++; $display("FAIL rstmid_residue_after[%0d] got %0d want 10", i, bus.residue[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int  acc [$];
    int  outs;
    bit  pre;
    outs = 0;
    set_in(0, 32767, 60);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      pre = bus.in_ready;
      if (bus.out_valid) begin
        outs++;
        n_cmp++; if (bus.residue[0] !== 8'sd127) begin n_bad++; $display("FAIL b2b_residue0 got %0d want 127", bus.residue[0]); end
        n_cmp++; if (bus.residue[10] !== 8'sd127) begin n_bad++; $display("FAIL b2b_residue10 got %0d want 127", bus.residue[10]); end
      end
      @(posedge clk);
      if (pre) acc.push_back(e);
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (acc.size() != 4) begin n_bad++; $display("FAIL b2b_accept_count got %0d want 4", acc.size()); end
    for (int k = 1; k < acc.size(); k++) begin
      n_cmp++; if (acc[k] - acc[k-1] != 12) begin n_bad++; $display("FAIL b2b_interval got %0d want 12", acc[k] - acc[k-1]); end
    end
    n_cmp++; if (outs != 3) begin n_bad++; $display("FAIL b2b_out_count got %0d want 3", outs); end
    for (int k = 0; k < 30 && bus.busy; k++) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_drain_busy got %b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_dc();
    test_pattern();
    test_saturate();
    test_qp_clamp();
    test_hold_out();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
